bus_wait_gen: RTL
=================

BUS_WAIT_GEN -- requirements
Module: bus_wait_gen

Interface
REQ-001 Parameters SHALL be: ADDRWID, default 20, bus address width; MEMSIZE, default 20'h40000, first nonexistent word address; TIMEOUT, default 64, maximum WAIT cycles before NXM (legal range 2..255).
REQ-002 clk  in  1  single clock; all state changes on its rising edge.
REQ-003 rst  in  1  synchronous, active-low reset.
REQ-004 busREQ  in  1  CPU memory request; level, held until busWAIT is seen low.
REQ-005 busWRITE  in  1  CPU write qualifier; sampled with busREQ in IDLE.
REQ-006 busADDR  in  ADDRWID  CPU word address; sampled with busREQ in IDLE.
REQ-007 memACK  in  1  memory controller completion; one or more cycles.
REQ-008 busWAIT  out  1  stall to CPU clock-enable logic; combinational.
REQ-009 memREQ  out  1  one-cycle request strobe to memory controller.
REQ-010 memWRITE  out  1  latched write qualifier.
REQ-011 memADDR  out  ADDRWID  latched address.
REQ-012 busNXM  out  1  sticky nonexistent-memory flag.
REQ-013 nxmADDR  out  ADDRWID  address of the most recent NXM event.
REQ-014 nxmCLR  in  1  clears busNXM.

Function
REQ-015 The state machine SHALL have the states IDLE, REQ, WAIT, DONE; a 8-bit WAIT cycle counter SHALL be provided.
REQ-016 busWAIT SHALL equal busREQ AND (state != DONE) AND rst, with no register in the path, so a new request stalls the CPU in the same cycle it appears.
REQ-017 IDLE with busREQ=1 and busADDR < MEMSIZE: latch busADDR/busWRITE into memADDR/memWRITE, go to REQ.
REQ-018 IDLE with busREQ=1 and busADDR >= MEMSIZE: latch the address, set busNXM, load nxmADDR, go to DONE without issuing memREQ.
REQ-019 REQ: memREQ=1 for exactly this cycle, clear the counter, go to WAIT.
REQ-020 WAIT with memACK=1: go to DONE, no NXM.
REQ-021 WAIT, memACK=0, counter == TIMEOUT-1: set busNXM, load nxmADDR from memADDR, go to DONE.
REQ-022 WAIT otherwise: increment the counter, stay in WAIT.
REQ-023 memACK and timeout in the same cycle: ACK wins, busNXM unchanged.
REQ-024 DONE SHALL last exactly one cycle (busWAIT=0), then go to IDLE.
REQ-025 If busREQ=1 in IDLE right after DONE, it SHALL be treated as a new request.
REQ-026 busREQ dropping in REQ or WAIT SHALL abort: next state IDLE, no NXM, no further memREQ.
REQ-027 memACK in IDLE, REQ or DONE SHALL be ignored.
REQ-028 memREQ SHALL never assert in two consecutive cycles.
REQ-029 busNXM set and nxmCLR in the same cycle: set SHALL win; nxmCLR alone clears busNXM on the next edge.
REQ-030 Latency SHALL be as follows, where busREQ rises at cycle 0 and memACK arrives in the first WAIT cycle:
- memREQ in cycle 1
- WAIT in cycle 2
- busWAIT low in cycle 3

Reset
REQ-031 While rst=0 at a rising edge, the next state SHALL be as follows, overriding any in-flight transaction:
- state=IDLE, counter=0
- memREQ=0, memWRITE=0, memADDR=0
- busNXM=0, nxmADDR=0
REQ-032 busWAIT SHALL be 0 whenever rst=0.

Verification
REQ-033 Normal read: busREQ=1, busADDR=20'h00100, busWRITE=0, memACK at cycle 2 -> memREQ pulse at cycle 1, memADDR=20'h00100, busWAIT=1 cycles 0-2 and 0 at cycle 3, busNXM=0.
REQ-034 Timeout: TIMEOUT=8, write to 20'h00200, memACK never asserted -> busWAIT low at cycle 10, busNXM=1, nxmADDR=20'h00200; nxmCLR pulse -> busNXM=0 next cycle.
REQ-035 Out of range: busADDR=20'h40000 -> no memREQ, busNXM=1 and busWAIT=0 at cycle 1, nxmADDR=20'h40000.
REQ-036 ACK/timeout race: TIMEOUT=8, memACK at cycle 9 -> DONE at cycle 10, busNXM=0; also nxmCLR coincident with a new NXM -> busNXM stays 1.
REQ-037 Abort and reset: busREQ dropped at cycle 3 in WAIT -> IDLE at cycle 4, late memACK ignored. Separately, rst=0 during WAIT -> all outputs at reset values next cycle and busWAIT=0 immediately.
REQ-038 Back-to-back: busREQ held high through DONE -> second memREQ exactly 2 cycles after DONE, no overlapping memREQ.

Source files
------------

// File: rtl/bus_wait_gen.sv
// Bus wait-state generator: stalls the CPU while a memory access is in flight,
// hands one-cycle requests to the memory controller and flags NXM on timeout or bad address.
module bus_wait_gen #(
  parameter int                 ADDRWID = 20,
  parameter logic [ADDRWID-1:0] MEMSIZE = 20'h40000,
  parameter int                 TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               busREQ,
  input  logic               busWRITE,
  input  logic [ADDRWID-1:0] busADDR,
  input  logic               memACK,
  output logic               busWAIT,
  output logic               memREQ,
  output logic               memWRITE,
  output logic [ADDRWID-1:0] memADDR,
  output logic               busNXM,
  output logic [ADDRWID-1:0] nxmADDR,
  input  logic               nxmCLR
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_e             state_q, state_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               mem_req_q, mem_req_d;
  logic               mem_write_q, mem_write_d;
  logic [ADDRWID-1:0] mem_addr_q, mem_addr_d;
  logic               nxm_q, nxm_d;
  logic [ADDRWID-1:0] nxm_addr_q, nxm_addr_d;
  logic               nxm_set;
  logic               in_range;

  assign in_range = (busADDR < MEMSIZE);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_req_d   = 1'b0;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    nxm_addr_d  = nxm_addr_q;
    nxm_set     = 1'b0;
    case (state_q)
      IDLE: begin
        if (busREQ) begin
          mem_addr_d  = busADDR;
          mem_write_d = busWRITE;
          if (in_range) begin
            // memREQ is registered, so it rises together with the REQ state
            state_d   = REQ;
            mem_req_d = 1'b1;
          end else begin
            nxm_set    = 1'b1;
            nxm_addr_d = busADDR;
            state_d    = DONE;
          end
        end
      end
      REQ: begin
        cnt_d   = 8'd0;
        state_d = busREQ ? WAIT : IDLE;
      end
      WAIT: begin
        if (!busREQ) begin
          state_d = IDLE;
        end else if (memACK) begin
          state_d = DONE;
        end else if (cnt_q == CNT_LAST) begin
          nxm_set    = 1'b1;
          nxm_addr_d = mem_addr_q;
          state_d    = DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // a fresh NXM event beats a coincident clear
    if (nxm_set)     nxm_d = 1'b1;
    else if (nxmCLR) nxm_d = 1'b0;
    else             nxm_d = nxm_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      mem_req_q   <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      nxm_q       <= 1'b0;
      nxm_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      nxm_q       <= nxm_d;
      nxm_addr_q  <= nxm_addr_d;
    end
  end

  // combinational so a new request stalls the CPU in the cycle it appears
  assign busWAIT  = busREQ & (state_q != DONE) & rst;
  assign memREQ   = mem_req_q;
  assign memWRITE = mem_write_q;
  assign memADDR  = mem_addr_q;
  assign busNXM   = nxm_q;
  assign nxmADDR  = nxm_addr_q;

endmodule
